// File: rtl/serial_compare_ctrl.sv
// Serial MSB-first magnitude comparator: walks two WIDTH-bit operands two bits per cycle
// through a pair of 2-bit greater-than comparators and reports gt/eq/lt with a start/done handshake.

module twobit_gt (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic       gt_o
);
    assign gt_o = (a_i > b_i);
endmodule

module serial_compare_ctrl #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);
    localparam int unsigned Half = WIDTH / 2;
    localparam int unsigned CntW = $clog2(Half + 1);

    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
        $error("serial_compare_ctrl: WIDTH must be even and >= 2");
    end

    typedef enum logic {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
    // Direction of the first unequal digit pair, used only in fixed-latency mode.
    logic              rec_gt_q, rec_gt_d, rec_lt_q, rec_lt_d;

    logic [1:0]        a_dig, b_dig;
    logic              dig_gt, dig_lt;
    logic              dec_gt, dec_lt;

    assign a_dig = a_q[WIDTH-1 -: 2];
    assign b_dig = b_q[WIDTH-1 -: 2];

    twobit_gt u_gt_ab (
        .a_i  (a_dig),
        .b_i  (b_dig),
        .gt_o (dig_gt)
    );

    twobit_gt u_gt_ba (
        .a_i  (b_dig),
        .b_i  (a_dig),
        .gt_o (dig_lt)
    );

    assign dec_gt = rec_gt_q | (~rec_gt_q & ~rec_lt_q & dig_gt);
    assign dec_lt = rec_lt_q | (~rec_gt_q & ~rec_lt_q & dig_lt);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        gt_d     = gt_q;
        eq_d     = eq_q;
        lt_d     = lt_q;
        rec_gt_d = rec_gt_q;
        rec_lt_d = rec_lt_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    cnt_d    = CntW'(Half);
                    gt_d     = 1'b0;
                    eq_d     = 1'b0;
                    lt_d     = 1'b0;
                    rec_gt_d = 1'b0;
                    rec_lt_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (EARLY_EXIT != 0) begin
                    if (dig_gt || dig_lt) begin
                        gt_d    = dig_gt;
                        lt_d    = dig_lt;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        a_d   = a_q << 2;
                        b_d   = b_q << 2;
                        cnt_d = cnt_q - CntW'(1);
                        if (cnt_q == CntW'(1)) begin
                            eq_d    = 1'b1;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = StIdle;
                        end
                    end
                end else begin
                    a_d   = a_q << 2;
                    b_d   = b_q << 2;
                    cnt_d = cnt_q - CntW'(1);
                    if (!rec_gt_q && !rec_lt_q) begin
                        rec_gt_d = dig_gt;
                        rec_lt_d = dig_lt;
                    end
                    if (cnt_q == CntW'(1)) begin
                        gt_d    = dec_gt;
                        lt_d    = dec_lt;
                        eq_d    = ~dec_gt & ~dec_lt;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
            rec_gt_q <= 1'b0;
            rec_lt_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            gt_q     <= gt_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
            rec_gt_q <= rec_gt_d;
            rec_lt_q <= rec_lt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gt   = gt_q;
    assign eq   = eq_q;
    assign lt   = lt_q;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Bench for serial_compare_ctrl: early-exit and fixed-latency instances side by side,
// expected flags and latency queued at launch and checked when done appears.

module tb_serial_compare_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] a = '0, b = '0;

    logic busy_e, done_e, gt_e, eq_e, lt_e;
    logic busy_f, done_f, gt_f, eq_f, lt_f;
    logic busy_x, done_x, gt_x, eq_x, lt_x;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic gt;
        logic eq;
        logic lt;
        int   lat;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    serial_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1)) u_ee (
        .clk   (clk),
        .rst   (rst),
        .start (start & ~sel),
        .a     (a),
        .b     (b),
        .busy  (busy_e),
        .done  (done_e),
        .gt    (gt_e),
        .eq    (eq_e),
        .lt    (lt_e)
    );

    serial_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(0)) u_fl (
        .clk   (clk),
        .rst   (rst),
        .start (start & sel),
        .a     (a),
        .b     (b),
        .busy  (busy_f),
        .done  (done_f),
        .gt    (gt_f),
        .eq    (eq_f),
        .lt    (lt_f)
    );

    assign busy_x = sel ? busy_f : busy_e;
    assign done_x = sel ? done_f : done_e;
    assign gt_x   = sel ? gt_f   : gt_e;
    assign eq_x   = sel ? eq_f   : eq_e;
    assign lt_x   = sel ? lt_f   : lt_e;

    function automatic exp_t model(input bit fx, input logic [7:0] av, input logic [7:0] bv);
        exp_t e;
        logic [7:0] x, y;
        bit found;
        e.gt  = (av > bv);
        e.eq  = (av == bv);
        e.lt  = (av < bv);
        e.lat = 4;
        if (!fx) begin
            x = av;
            y = bv;
            found = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (!found && (x[7:6] != y[7:6])) begin
                    e.lat = i + 1;
                    found = 1'b1;
                end
                x = x << 2;
                y = y << 2;
            end
        end
        return e;
    endfunction

    // Entered at the negedge after the accepting edge; returns at the negedge showing done.
    task automatic wait_done(input string nm, input bit perturb, output exp_t e, output bit ok);
        int busy_cycles = 0;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done_x === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (busy_x === 1'b1) busy_cycles++;
            if (perturb) begin
                start = ~start;
                a = 8'($urandom);
                b = 8'($urandom);
            end
            @(negedge clk);
        end
        if (sb_q.size() > 0) e = sb_q.pop_front();
        else e = '{gt: 1'b0, eq: 1'b0, lt: 1'b0, lat: 0};
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s timeout: done not seen within 20 cycles, required within %0d", nm,
                     e.lat);
            return;
        end
        if ({gt_x, eq_x, lt_x} !== {e.gt, e.eq, e.lt}) begin
            n_err++;
            $display("FAIL %s flags: got gt/eq/lt=%b%b%b required %b%b%b", nm, gt_x, eq_x, lt_x,
                     e.gt, e.eq, e.lt);
        end
        n_cmp++;
        if (busy_cycles != e.lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d busy cycles required %0d", nm, busy_cycles, e.lat);
        end
        n_cmp++;
        if (busy_x !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy_at_done: got %b required 0", nm, busy_x);
        end
    endtask

    task automatic run_op(input bit fx, input logic [7:0] av, input logic [7:0] bv,
                          input string nm);
        exp_t e;
        bit ok;
        @(negedge clk);
        sel = fx;
        a = av;
        b = bv;
        start = 1'b1;
        sb_q.push_back(model(fx, av, bv));
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if ({busy_x, gt_x, eq_x, lt_x} !== 4'b1000) begin
            n_err++;
            $display("FAIL %s accept: got busy,gt,eq,lt=%b%b%b%b required 1000", nm, busy_x,
                     gt_x, eq_x, lt_x);
        end
        wait_done(nm, 1'b0, e, ok);
        if (ok) begin
            @(negedge clk);
            n_cmp++;
            if (done_x !== 1'b0) begin
                n_err++;
                $display("FAIL %s done_pulse: got done=%b one cycle later required 0", nm, done_x);
            end
            n_cmp++;
            if ({gt_x, eq_x, lt_x} !== {e.gt, e.eq, e.lt}) begin
                n_err++;
                $display("FAIL %s flags_hold: got %b%b%b required %b%b%b", nm, gt_x, eq_x, lt_x,
                         e.gt, e.eq, e.lt);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({busy_e, done_e, gt_e, eq_e, lt_e, busy_f, done_f, gt_f, eq_f, lt_f} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got ee=%b%b%b%b%b fl=%b%b%b%b%b required all 0",
                     busy_e, done_e, gt_e, eq_e, lt_e, busy_f, done_f, gt_f, eq_f, lt_f);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({done_e, done_f, busy_e, busy_f} !== 4'b0) begin
                n_err++;
                $display("FAIL reset_idle: got done=%b%b busy=%b%b required 0000", done_e,
                         done_f, busy_e, busy_f);
            end
        end
    endtask

    task automatic test_early_exit();
        run_op(1'b0, 8'hC3, 8'h43, "ee_first_digit_gt");
        run_op(1'b0, 8'h5A, 8'h5B, "ee_last_digit_lt");
        run_op(1'b0, 8'hA5, 8'hA5, "ee_equal");
    endtask

    task automatic test_fixed_latency();
        run_op(1'b1, 8'hC0, 8'h3F, "fl_first_digit_gt");
        run_op(1'b1, 8'h0F, 8'h4C, "fl_first_digit_lt");
        run_op(1'b1, 8'hA5, 8'hA5, "fl_equal");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit ok;
        @(negedge clk);
        sel = 1'b0;
        a = 8'h5A;
        b = 8'h5B;
        start = 1'b1;
        sb_q.push_back(model(1'b0, 8'h5A, 8'h5B));
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_first_perturbed", 1'b1, e, ok);
        // New request lands in the done cycle itself.
        a = 8'h01;
        b = 8'h02;
        start = 1'b1;
        sb_q.push_back(model(1'b0, 8'h01, 8'h02));
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if ({busy_x, done_x, gt_x, eq_x, lt_x} !== 5'b10000) begin
            n_err++;
            $display("FAIL b2b_accept: got busy,done,gt,eq,lt=%b%b%b%b%b required 10000",
                     busy_x, done_x, gt_x, eq_x, lt_x);
        end
        wait_done("b2b_second", 1'b0, e, ok);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        bit bad = 1'b0;
        @(negedge clk);
        sel = 1'b0;
        a = 8'hA5;
        b = 8'hA5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy_x !== 1'b1) begin
            n_err++;
            $display("FAIL mid_run_busy: got busy=%b after E2 required 1", busy_x);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy_x, done_x, gt_x, eq_x, lt_x} !== 5'b0) begin
            n_err++;
            $display("FAIL async_reset: got busy,done,gt,eq,lt=%b%b%b%b%b required 00000",
                     busy_x, done_x, gt_x, eq_x, lt_x);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_x !== 1'b0 || busy_x !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL abort_no_done: got done or busy after aborted op, required none");
        end
    endtask

    task automatic test_random();
        logic [7:0] av, bv;
        for (int i = 0; i < 10; i++) begin
            av = 8'($urandom);
            case (i % 3)
                0: bv = av;
                1: bv = {av[7:4], 4'($urandom)};
                default: bv = 8'($urandom);
            endcase
            run_op(1'((i / 2) % 2), av, bv, "random");
        end
    endtask

    initial begin
        test_reset();
        test_early_exit();
        test_fixed_latency();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_compare_ctrl.md
Name: serial_compare_ctrl

Overview:
Sequential magnitude-compare controller. It compares two WIDTH-bit unsigned operands two bits per cycle, MSB-first, by driving digit pairs through two instances of the existing 2-bit greater-than comparator (twobit_gt): one for a>b and one for b>a. It owns the start/busy/done handshake, the digit counter and the result flags, so wide comparisons reuse the 2-bit comparator instead of a flat wide comparator.

Parameters:
WIDTH, 8, operand width in bits. Must be even and >= 2; elaboration fails otherwise.
EARLY_EXIT, 1, 1 = finish at the first unequal digit pair; 0 = always scan all WIDTH/2 digits (fixed latency).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request a compare; sampled only when the block is not busy.
a  input  WIDTH  operand A; sampled on the edge that accepts start.
b  input  WIDTH  operand B; sampled on the edge that accepts start.
busy  output  1  high while a compare is in progress.
done  output  1  one-cycle pulse; result flags are valid from this cycle onward.
gt  output  1  A > B.
eq  output  1  A == B.
lt  output  1  A < B.

Behaviour:
- Reset (async, rst=1): state IDLE; busy, done, gt, eq, lt = 0; operand shift registers, digit counter and first-difference record = 0. Reset mid-RUN aborts the operation immediately. No done pulse is produced for an aborted operation.
- States: IDLE, RUN. Counter width is $clog2(WIDTH/2+1).
- IDLE, start=1 at edge E0: load a and b into shift registers; counter <= WIDTH/2; clear gt, eq and lt; busy <= 1; go to RUN.
- RUN, each edge: compare the top 2 bits of each shift register with the two twobit_gt instances. Digit equality means neither instance asserts.
  - EARLY_EXIT=1: a-digit greater -> gt <= 1. b-digit greater -> lt <= 1. In both cases also done <= 1, busy <= 0, go to IDLE. Otherwise shift both registers left by 2 and decrement the counter. If the counter was 1, set eq <= 1, done <= 1, busy <= 0 and go to IDLE.
  - EARLY_EXIT=0: latch the direction of the first unequal digit only; later digits are ignored. Always run WIDTH/2 edges. On the last edge, set gt, lt or eq from the latched record, and set done and busy as above.
- Latency: busy is high from E0 to En, where n = index of the deciding digit, in the range 1..WIDTH/2 (n = WIDTH/2 when EARLY_EXIT=0). done is high for exactly the cycle following En.
- Exactly one of gt, eq and lt is 1 after done. The flags hold until the next accepted start, which clears them.
- start while busy is ignored. Operands may change freely while busy without affecting the result.
- start high during the done cycle (state is already IDLE) is accepted: back-to-back operations with no gap.
- start held continuously high launches a new compare each time the block returns to IDLE.
- done is never asserted without a preceding accepted start.

Test Plan:
- WIDTH=8, EARLY_EXIT=1, a=8'hC3, b=8'h43, start pulse -> busy for 1 cycle; done pulses after E1; gt=1, eq=0, lt=0.
- a=8'h5A, b=8'h5B -> first three digits equal, fourth 10<11; busy for 4 cycles; done after E4; lt=1.
- a=b=8'hA5 -> busy for 4 cycles; done after E4; eq=1, gt=0, lt=0.
- EARLY_EXIT=0, a=8'hC0, b=8'h3F -> first digit decides but busy stays high for 4 cycles; done after E4; gt=1; later digits 00<11 do not flip the result.
- During busy, toggle start and change a and b -> result unchanged. Then start with a=8'h01, b=8'h02 in the done cycle -> new op accepted without an idle cycle; flags cleared at acceptance; lt=1 after 4 cycles.
- Assert rst mid-RUN (after E2 of the a=b=8'hA5 case) -> busy, done, gt, eq, lt go to 0 without waiting for clk. After release, no done pulse appears until a new start is given.
